msdf_local_x_reader: RTL and testbench



---
 rtl/msdf_local_x_reader_if.sv | 21 ++
 rtl/msdf_local_x_reader.sv | 132 +++++++++++++
 tb/tb_msdf_local_x_reader.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/msdf_local_x_reader_if.sv
// Digit-serial output stream of the local_x reader: parallel lanes of {last, d1, d0}
// with a valid/ready handshake.
interface msdf_local_x_reader_if #(
    parameter int unsigned NUM_GRADIENT = 4
);
    logic [NUM_GRADIENT*3-1:0] dataOutArray_0;
    logic                      validArray_0;
    logic                      nReadyArray_0;

    modport master (
        output dataOutArray_0,
        output validArray_0,
        input  nReadyArray_0
    );

    modport slave (
        input  dataOutArray_0,
        input  validArray_0,
        output nReadyArray_0
    );
endinterface

// File: rtl/msdf_local_x_reader.sv
// Streams one TARGET_PRECISION-digit MSDF vector out of local_x RAM (MSD first) through a
// 2-entry FIFO, tagging the final digit with the per-lane last flag.
module msdf_local_x_reader #(
    parameter int unsigned TARGET_PRECISION = 25,
    parameter int unsigned NUM_GRADIENT     = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    output logic                      busy,
    output logic                      done,
    output logic [8:0]                local_x_addrb,
    input  logic [NUM_GRADIENT*3-1:0] local_x_doutb,
    msdf_local_x_reader_if.master     out_if
);
    localparam int unsigned CntW = $clog2(TARGET_PRECISION) + 1;
    localparam int unsigned W    = NUM_GRADIENT * 3;
    localparam logic [CntW-1:0] LastIdx = CntW'(TARGET_PRECISION - 1);

    typedef enum logic [1:0] {StIdle, StRead, StDrain} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] rd_cnt_q, rd_cnt_d;
    logic [CntW-1:0] out_cnt_q, out_cnt_d;
    logic [8:0]      addr_q, addr_d;
    logic            pend_q, pend_d;
    logic            pend_last_q, pend_last_d;
    logic [W-1:0]    fifo_q [2];
    logic            wr_ptr_q, rd_ptr_q;
    logic [1:0]      fifo_cnt_q;
    logic            issue, push, pop, credit_ok;
    logic [W-1:0]    push_word;

    assign push = pend_q;
    assign pop  = out_if.validArray_0 & out_if.nReadyArray_0;
    // A pop this cycle frees a slot, which keeps the stream at one digit per cycle.
    assign credit_ok = ({1'b0, fifo_cnt_q} + {2'b00, pend_q}) < (3'd2 + {2'b00, pop});

    always_comb begin
        push_word = '0;
        for (int i = 0; i < int'(NUM_GRADIENT); i++) begin
            push_word[3*i +: 2] = local_x_doutb[3*i +: 2];
            push_word[3*i + 2]  = pend_last_q;
        end
    end

    always_comb begin
        state_d     = state_q;
        rd_cnt_d    = rd_cnt_q;
        out_cnt_d   = out_cnt_q;
        addr_d      = addr_q;
        issue       = 1'b0;
        done        = 1'b0;
        pend_last_d = 1'b0;
        if (pop) out_cnt_d = out_cnt_q + 1'b1;
        unique case (state_q)
            StIdle: begin
                // Address 0 goes out with the accepted start so the first digit is
                // valid two cycles later.
                if (start) begin
                    issue       = 1'b1;
                    addr_d      = '0;
                    rd_cnt_d    = CntW'(1);
                    out_cnt_d   = '0;
                    pend_last_d = (LastIdx == '0);
                    state_d     = (LastIdx == '0) ? StDrain : StRead;
                end
            end
            StRead: begin
                if (credit_ok) begin
                    issue       = 1'b1;
                    addr_d      = 9'(rd_cnt_q);
                    rd_cnt_d    = rd_cnt_q + 1'b1;
                    pend_last_d = (rd_cnt_q == LastIdx);
                    if (rd_cnt_q == LastIdx) state_d = StDrain;
                end
            end
            StDrain: begin
                if (pop && (out_cnt_q == LastIdx)) begin
                    done    = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        pend_d = issue;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            rd_cnt_q    <= '0;
            out_cnt_q   <= '0;
            addr_q      <= '0;
            pend_q      <= 1'b0;
            pend_last_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rd_cnt_q    <= rd_cnt_d;
            out_cnt_q   <= out_cnt_d;
            addr_q      <= addr_d;
            pend_q      <= pend_d;
            pend_last_q <= pend_last_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fifo_q[0]  <= '0;
            fifo_q[1]  <= '0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            fifo_cnt_q <= '0;
        end else begin
            if (push) begin
                fifo_q[wr_ptr_q] <= push_word;
                wr_ptr_q         <= ~wr_ptr_q;
            end
            if (pop) rd_ptr_q <= ~rd_ptr_q;
            unique case ({push, pop})
                2'b10:   fifo_cnt_q <= fifo_cnt_q + 2'd1;
                2'b01:   fifo_cnt_q <= fifo_cnt_q - 2'd1;
                default: fifo_cnt_q <= fifo_cnt_q;
            endcase
        end
    end

    assign busy                  = (state_q != StIdle);
    assign local_x_addrb         = addr_q;
    assign out_if.validArray_0   = (fifo_cnt_q != 2'd0);
    assign out_if.dataOutArray_0 = fifo_q[rd_ptr_q];
endmodule

// File: tb/tb_msdf_local_x_reader.sv
// Directed bench for msdf_local_x_reader: streaming, back-pressure, ignored starts and
// asynchronous reset, checked against hand-built expected words.
module tb_msdf_local_x_reader;
    localparam int TP = 25;
    localparam int NG = 4;
    localparam int W  = NG * 3;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         nready = 1'b1;
    logic         busy, done;
    logic [8:0]   addrb;
    logic [W-1:0] doutb;

    int checks = 0;
    int errors = 0;

    msdf_local_x_reader_if #(.NUM_GRADIENT(NG)) out_if ();

    msdf_local_x_reader #(
        .TARGET_PRECISION(TP),
        .NUM_GRADIENT    (NG)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .busy         (busy),
        .done         (done),
        .local_x_addrb(addrb),
        .local_x_doutb(doutb),
        .out_if       (out_if)
    );

    always #5 clk = ~clk;

    // RAM word at address a: lane i holds digit (a+i) mod 4, with bit 2 set to garbage 1.
    function automatic logic [W-1:0] ram_word(input logic [8:0] a);
        logic [W-1:0] w;
        w = '0;
        for (int i = 0; i < NG; i++) w[3*i +: 3] = {1'b1, 2'(int'(a) + i)};
        return w;
    endfunction

    function automatic logic [W-1:0] exp_word(input int j);
        logic [W-1:0] w;
        w = '0;
        for (int i = 0; i < NG; i++) w[3*i +: 3] = {(j == TP - 1), 2'(j + i)};
        return w;
    endfunction

    assign doutb                = ram_word(addrb);
    assign out_if.nReadyArray_0 = nready;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // mode 0: ready held, 1: ready toggles, 2: ready low for cycles 0..10.
    task automatic run_stream(input int mode, input bit restart_mid, input bit start_at_end);
        int idx = 0;
        int dones = 0;
        int done_cyc = -1;
        int exp_addr = 0;
        logic [8:0] prev_addr = '0;
        bit pulsed = 0;
        bit xfer;
        for (int cyc = 0; cyc < 200 && done_cyc < 0; cyc++) begin
            @(posedge clk);
            #1;
            case (mode)
                1:       nready = cyc[0];
                2:       nready = (cyc > 10);
                default: nready = 1'b1;
            endcase
            start = (cyc == 0);
            if (restart_mid && !pulsed && idx == 10) begin
                start  = 1'b1;
                pulsed = 1;
            end
            if (start_at_end && idx == TP - 1 && out_if.validArray_0 && nready) start = 1'b1;
            #1;
            xfer = out_if.validArray_0 && nready;
            if (cyc == 0) check("busy_before_start", busy, 0);
            if (cyc == 1) begin
                check("busy_after_start", busy, 1);
                check("first_addr", addrb, 0);
                exp_addr  = 1;
                prev_addr = addrb;
            end else if (cyc > 1 && addrb != prev_addr) begin
                check("addr_order", addrb, exp_addr);
                exp_addr++;
                prev_addr = addrb;
            end
            if (mode == 0 && cyc == 1) check("valid_cyc1", out_if.validArray_0, 0);
            if (mode == 0 && cyc == 2) check("valid_cyc2", out_if.validArray_0, 1);
            if (mode == 2 && cyc == 10) begin
                check("stall_reads", (addrb <= 9'd1), 1);
                check("stall_valid", out_if.validArray_0, 1);
            end
            if (out_if.validArray_0 && !nready)
                check("head_stable", out_if.dataOutArray_0, exp_word(idx));
            check("done_pulse", done, (xfer && idx == TP - 1));
            if (xfer) begin
                check("data", out_if.dataOutArray_0, exp_word(idx));
                idx++;
            end
            if (done) begin
                dones++;
                done_cyc = cyc;
            end
        end
        check("digit_count", idx, TP);
        check("addr_count", exp_addr, TP);
        check("done_count", dones, 1);
        if (mode == 0) check("done_cycle", done_cyc, TP + 1);
        @(posedge clk);
        #1;
        start  = 1'b0;
        nready = 1'b1;
        #1;
        check("busy_after_done", busy, 0);
        check("valid_after_done", out_if.validArray_0, 0);
    endtask

    initial begin
        int n;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_valid", out_if.validArray_0, 0);
        check("rst_addr", addrb, 0);
        check("rst_done", done, 0);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("idle_valid", out_if.validArray_0, 0);

        run_stream(0, 0, 0);
        run_stream(1, 0, 0);
        run_stream(2, 0, 0);
        run_stream(0, 1, 0);

        // Asynchronous reset in the middle of the stream.
        @(posedge clk);
        #1;
        start  = 1'b1;
        nready = 1'b1;
        n      = 0;
        for (int c = 0; c < 100 && n < 12; c++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            #1;
            if (out_if.validArray_0 && nready) n++;
        end
        check("rst_reach_digit12", n, 12);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("async_valid", out_if.validArray_0, 0);
        check("async_busy", busy, 0);
        check("async_addr", addrb, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("post_rst_valid", out_if.validArray_0, 0);
        check("post_rst_addr", addrb, 0);
        check("post_rst_busy", busy, 0);

        run_stream(0, 0, 0);
        run_stream(0, 0, 1);
        run_stream(0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
